// File: rtl/spi_sclk_gen.sv
// SPI master SCLK / chip-select frame generator with run-time divider, frame length
// and CPOL/CPHA; issues launch/sample strobes for the data shifter.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             cs_n,
    output logic             busy,
    output logic             launch,
    output logic             sample,
    output logic             done
);

    // Handshake: start is a request taken only while the generator is idle (busy low);
    // launch, sample and done are single-cycle strobes with no back-pressure.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        RUN  = 2'd2,
        LAG  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] hc;
    logic [DIV_W-1:0] hc_n;
    logic [DIV_W-1:0] div_l;
    logic [CNT_W-1:0] nbits_l;
    logic [CNT_W:0]   e;
    logic [CNT_W:0]   e_n;
    logic [CNT_W:0]   edge_k;
    logic [CNT_W:0]   last_edge;
    logic             cpol_l;
    logic             cpha_l;
    logic             tick;
    logic             latch_en;
    logic             launch_q;
    logic             first_launch;
    logic             sclk_n;
    logic             cs_n_n;
    logic             busy_n;
    logic             launch_n;
    logic             sample_n;
    logic             done_n;

    assign tick      = (hc == div_l);
    assign edge_k    = e + (CNT_W+1)'(1);
    assign last_edge = {nbits_l, 1'b0};

    // With CPHA=0 the first bit must be on the wire as CS falls, so that launch is
    // decoded straight from the accepted start rather than waiting for a register.
    assign first_launch = !rst && (state == IDLE) && start && (nbits != '0) && !cpha;
    assign launch       = launch_q | first_launch;

    always_comb begin
        state_n  = state;
        hc_n     = tick ? '0 : hc + DIV_W'(1);
        e_n      = e;
        sclk_n   = sclk;
        cs_n_n   = cs_n;
        busy_n   = busy;
        launch_n = 1'b0;
        sample_n = 1'b0;
        done_n   = 1'b0;
        latch_en = 1'b0;

        case (state)
            IDLE: begin
                hc_n   = '0;
                sclk_n = cpol_l;
                if (start) begin
                    latch_en = 1'b1;
                    sclk_n   = cpol;
                    e_n      = '0;
                    if (nbits == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = LEAD;
                        cs_n_n  = 1'b0;
                        busy_n  = 1'b1;
                    end
                end
            end
            LEAD, RUN: begin
                if (tick) begin
                    sclk_n = ~sclk;
                    e_n    = edge_k;
                    // Odd edges are the leading edge of each SCLK cycle.
                    if (edge_k[0]) begin
                        if (cpha_l) launch_n = 1'b1;
                        else        sample_n = 1'b1;
                    end else begin
                        if (cpha_l)                  sample_n = 1'b1;
                        else if (edge_k != last_edge) launch_n = 1'b1;
                    end
                    if (state == LEAD)              state_n = RUN;
                    else if (edge_k == last_edge)   state_n = LAG;
                end
            end
            LAG: begin
                if (tick) begin
                    state_n = IDLE;
                    cs_n_n  = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort wins over start and tick; the frame is dropped without done.
        if (abort && state != IDLE) begin
            state_n  = IDLE;
            hc_n     = '0;
            e_n      = '0;
            sclk_n   = cpol_l;
            cs_n_n   = 1'b1;
            busy_n   = 1'b0;
            launch_n = 1'b0;
            sample_n = 1'b0;
            done_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hc       <= '0;
            e        <= '0;
            div_l    <= '0;
            nbits_l  <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            launch_q <= 1'b0;
            sample   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            hc       <= hc_n;
            e        <= e_n;
            sclk     <= sclk_n;
            cs_n     <= cs_n_n;
            busy     <= busy_n;
            launch_q <= launch_n;
            sample   <= sample_n;
            done     <= done_n;
            if (latch_en) begin
                div_l   <= div;
                nbits_l <= nbits;
                cpol_l  <= cpol;
                cpha_l  <= cpha;
            end
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomized scoreboard bench for spi_sclk_gen: a timing-formula model predicts
// per-cycle sclk/cs_n/busy and the ordered strobe stream.
`timescale 1ns/1ps
module tb_spi_sclk_gen;
  localparam int DIV_W = 8;
  localparam int CNT_W = 6;
  localparam int MAXC  = 60000;
  localparam logic [1:0] EV_DONE   = 2'd0;
  localparam logic [1:0] EV_LAUNCH = 2'd1;
  localparam logic [1:0] EV_SAMPLE = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [CNT_W-1:0] nbits = '0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic sclk, cs_n, busy, launch, sample, done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div(div), .nbits(nbits),
    .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n), .busy(busy),
    .launch(launch), .sample(sample), .done(done)
  );

  // reference model state
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  bit exp_sclk[MAXC];
  bit exp_cs[MAXC];
  bit exp_busy[MAXC];
  int model_free = 0;
  int last_acc = -1;
  bit model_pol = 1'b0;

  function automatic void fill_idle(input int from, input bit pol);
    for (int q = from; q < MAXC; q++) begin
      exp_sclk[q] = pol;
      exp_cs[q]   = 1'b1;
      exp_busy[q] = 1'b0;
    end
  endfunction

  function automatic void push_ev(input int p, input logic [1:0] t);
    logic [29:0] pp;
    pp = p[29:0];
    exp_q.push_back({pp, t});
  endfunction

  function automatic void trim_from(input int q);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (int'(exp_q[i][31:2]) >= q) exp_q.delete(i);
  endfunction

  // Frame accepted in cycle p: edge k shows at p+1+k*(d+1), done at p+1+(2n+1)*(d+1).
  function automatic void model_start(input int p, input int n, input int d, input bit pol, input bit pha);
    int t, dn;
    last_acc  = p;
    model_pol = pol;
    fill_idle(p + 1, pol);
    if (n == 0) begin
      push_ev(p + 1, EV_DONE);
      model_free = p + 1;
      return;
    end
    t  = d + 1;
    dn = p + 1 + (2 * n + 1) * t;
    for (int q = p + 1; q < dn && q < MAXC; q++) begin
      exp_cs[q]   = 1'b0;
      exp_busy[q] = 1'b1;
      exp_sclk[q] = pol ^ bit'(((q - p - 1) / t) % 2);
    end
    if (!pha) push_ev(p, EV_LAUNCH);
    for (int k = 1; k <= 2 * n; k++) begin
      if (k % 2 == 1)      push_ev(p + 1 + k * t, pha ? EV_LAUNCH : EV_SAMPLE);
      else if (pha)        push_ev(p + 1 + k * t, EV_SAMPLE);
      else if (k != 2 * n) push_ev(p + 1 + k * t, EV_LAUNCH);
    end
    push_ev(dn, EV_DONE);
    model_free = dn;
  endfunction

  function automatic void model_abort(input int a);
    trim_from(a + 1);
    fill_idle(a + 1, model_pol);
    model_free = a + 1;
  endfunction

  function automatic void model_reset(input int r);
    trim_from(r + 1);
    fill_idle(r + 1, 1'b0);
    model_pol  = 1'b0;
    model_free = r + 1;
  endfunction

  // scoreboard monitor
  task automatic check_ev(input bit v, input logic [1:0] t, input int q);
    logic [29:0] qq;
    qq = q[29:0];
    if (v) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0] == {qq, t}) begin
        void'(exp_q.pop_front());
      end else begin
        failures++;
        $display("FAIL strobe cyc=%0d got_type=%0d expected_head=%0h", q, t,
                 (exp_q.size() > 0) ? exp_q[0] : 32'hffffffff);
      end
    end
  endtask

  always @(negedge clk) begin
    int q;
    q = cyc;
    if (q < MAXC) begin
      checks++;
      if ({sclk, cs_n, busy} !== {exp_sclk[q], exp_cs[q], exp_busy[q]}) begin
        failures++;
        $display("FAIL pins cyc=%0d sclk/cs_n/busy got=%b%b%b expected=%b%b%b", q,
                 sclk, cs_n, busy, exp_sclk[q], exp_cs[q], exp_busy[q]);
      end
    end
    while (exp_q.size() > 0 && int'(exp_q[0][31:2]) < q) begin
      checks++;
      failures++;
      $display("FAIL missed_strobe cyc=%0d got=none expected_cyc=%0d type=%0d", q,
               exp_q[0][31:2], exp_q[0][1:0]);
      void'(exp_q.pop_front());
    end
    check_ev(done, EV_DONE, q);
    check_ev(launch, EV_LAUNCH, q);
    check_ev(sample, EV_SAMPLE, q);
  end

  // driver tasks
  task automatic drive(input bit s, input bit ab, input int n, input int d, input bit pol, input bit pha);
    int q;
    start = s;
    abort = ab;
    nbits = n[CNT_W-1:0];
    div   = d[DIV_W-1:0];
    cpol  = pol;
    cpha  = pha;
    q = cyc;
    if (ab && q > last_acc && q < model_free) model_abort(q);
    else if (s && q >= model_free)            model_start(q, int'(nbits), int'(div), pol, pha);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, $urandom_range(0, 63), $urandom_range(0, 255),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Runs out the current frame with stray starts and changing inputs, optionally aborting.
  task automatic wait_free(input bit allow_abort);
    int budget;
    budget = 0;
    while (cyc < model_free && budget < 20000) begin
      drive($urandom_range(0, 4) == 0, allow_abort && ($urandom_range(0, 99) == 0),
            $urandom_range(0, 63), $urandom_range(0, 255),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      budget++;
    end
    if (budget >= 20000) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout got=budget_exhausted expected=frame_end_by_%0d", model_free);
    end
  endtask

  initial begin
    int p;
    fill_idle(0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // div=0, N=1, mode 0
    drive(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
    wait_free(1'b0);
    idle(3);

    // div=3, N=8, mode 3
    drive(1'b1, 1'b0, 8, 3, 1'b1, 1'b1);
    wait_free(1'b0);
    idle(3);

    // empty frame
    drive(1'b1, 1'b0, 0, 2, 1'b1, 1'b0);
    idle(3);

    // abort at edge 5 of N=4, div=1, then a normal frame
    p = cyc;
    drive(1'b1, 1'b0, 4, 1, 1'b0, 1'b0);
    while (cyc < p + 11) drive(1'b0, 1'b0, 7, 9, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4, 1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3, 0, 1'b1, 1'b0);
    wait_free(1'b0);
    idle(2);

    // start held high: back-to-back frames
    repeat (30) drive(1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
    wait_free(1'b0);
    idle(2);

    // asynchronous reset mid-RUN
    p = cyc;
    drive(1'b1, 1'b0, 6, 2, 1'b1, 1'b0);
    while (cyc < p + 12) drive(1'b0, 1'b0, 5, 5, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sclk, cs_n, busy, launch, sample, done} !== 6'b010000) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b%b%b%b expected=010000",
               sclk, cs_n, busy, launch, sample, done);
    end
    model_reset(cyc);
    #1;
    rst = 1'b0;
    idle(3);

    // width boundaries
    drive(1'b1, 1'b0, 1, 255, 1'b0, 1'b1);
    wait_free(1'b0);
    idle(1);
    drive(1'b1, 1'b0, 63, 0, 1'b1, 1'b0);
    wait_free(1'b0);
    idle(2);

    // randomized frames with occasional aborts
    repeat (25) begin
      drive(1'b1, 1'b0, $urandom_range(0, 12), $urandom_range(0, 5),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_free(1'b1);
      idle($urandom_range(0, 2));
    end

    wait_free(1'b0);
    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_strobes got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
